key_flip_flop: RTL and testbench
================================

Name: key_flip_flop

Overview:
- Single-clock registered key-to-LED stage.
- Samples the key input on every rising clock edge and drives the LED output from that register. Output latency is one cycle.
- Also provides one-cycle edge pulses and a saturating transition counter for board-level debug.
- Sits between the key input pin and the LED driver. No debounce is performed.

Parameters:
- CNT_W, 8, width of the transition counter `change_cnt` (legal range 1..32).

Ports:
- sys_clk  input  1  system clock, 50 MHz, rising-edge active.
- sys_rst_n  input  1  reset, synchronous, active-low.
- key_in  input  1  raw key level; assumed synchronous to sys_clk.
- led_out  output  1  registered copy of key_in.
- key_rise  output  1  one-cycle pulse, asserted when led_out goes 0->1.
- key_fall  output  1  one-cycle pulse, asserted when led_out goes 1->0.
- change_cnt  output  CNT_W  saturating count of led_out transitions since reset.

Behaviour:
- Reset and clocking:
  - One clock: sys_clk.
  - Reset is synchronous and active-low: sys_rst_n is sampled only on the rising edge of sys_clk. There are no asynchronous paths.
  - Reset values: led_out=0, key_rise=0, key_fall=0, change_cnt=0.
- At each rising edge with sys_rst_n=0:
  - All registers load their reset values.
  - key_in is ignored.
- At each rising edge with sys_rst_n=1:
  - led_out <= key_in.
  - key_rise <= key_in & ~led_out.
  - key_fall <= ~key_in & led_out.
  - If key_in != led_out and change_cnt != all-ones: change_cnt <= change_cnt + 1.
  - Otherwise change_cnt holds.
- All outputs are driven directly from registers; there is no combinational path from input to output.
- Latency:
  - key_in to led_out is exactly 1 clock.
  - key_rise and key_fall assert in the same cycle that led_out takes its new value, for exactly one cycle.
- key_rise and key_fall are mutually exclusive and never both high.
- If key_in holds its value, neither pulse fires.
- If key_in toggles every cycle, led_out toggles every cycle, and key_rise and key_fall alternate high on consecutive cycles.
- change_cnt saturates at 2^CNT_W-1. There is no wrap-around.
- Reset mid-operation:
  - All outputs clear at the next edge.
  - Any pulse in progress is truncated.
  - change_cnt restarts from 0.
- First edge after reset release:
  - led_out is 0 after reset, so key_in=1 produces key_rise=1 and change_cnt=1.
  - key_in=0 produces nothing.
- key_in glitches shorter than one clock and between edges are not seen. Metastability handling is the caller's responsibility.

Optional Feature:
- Macro: KEY_FLIP_FLOP_STATS_EN.
- Defined: change_cnt behaves as described above.
- Undefined:
  - The counter register is not built and change_cnt is tied to 0.
  - led_out, key_rise and key_fall behaviour is unchanged.

Test Plan:
- Reset: hold sys_rst_n=0 for 1 edge with key_in=1 -> led_out=0, key_rise=0, key_fall=0, change_cnt=0.
- Latency: release reset, drive key_in=1 before edge N -> led_out=1 and key_rise=1 after edge N; after edge N+1 key_rise=0 and led_out=1.
- Falling edge and counting: starting from led_out=1, drive key_in=0 -> key_fall=1 for one cycle, led_out=0, change_cnt increments by 1.
- Random stream: drive random key_in updated every 2 clocks (40 ns at 20 ns period) -> on every cycle led_out equals key_in from the previous edge, and change_cnt equals the number of led_out transitions since reset.
- Mid-run reset: drop sys_rst_n for 2 edges while key_in=1 and change_cnt=5 -> all outputs 0. On the first edge after release, led_out=1, key_rise=1, change_cnt=1.
- Saturation: with CNT_W=2, toggle key_in every cycle for 6 cycles -> change_cnt counts 1,2,3 then holds at 3.

Source files
------------

// File: rtl/key_flip_flop.sv
// key_flip_flop: registered key-to-LED stage.
//
// The key level is sampled on every rising edge of sys_clk and drives led_out
// one cycle later. Two one-cycle pulses, key_rise and key_fall, mark led_out
// transitions. A saturating counter, change_cnt, counts transitions since reset
// for board-level debug.
//
// Build option KEY_FLIP_FLOP_STATS_EN:
//   defined   - change_cnt counts led_out transitions and saturates at all-ones.
//   undefined - the counter register is not built and change_cnt is tied to 0.
//
// Reset is synchronous and active-low. Every output comes directly from a
// register, so there is no combinational path from key_in to any output.
// No debounce is done here. The caller must supply a key_in that is already
// synchronous to sys_clk.
module key_flip_flop #(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             key_in,
    output logic             led_out,
    output logic             key_rise,
    output logic             key_fall,
    output logic [CNT_W-1:0] change_cnt
);

    logic led_q,  led_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next state of the LED register and the edge pulses.
    // Each pulse compares the incoming key against the LED value it replaces.
    always_comb begin
        led_d  = key_in;
        rise_d = key_in & ~led_q;
        fall_d = ~key_in & led_q;
    end

    // LED and pulse registers. A synchronous reset clears them and ends any pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            led_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign led_out  = led_q;
    assign key_rise = rise_q;
    assign key_fall = fall_q;

`ifdef KEY_FLIP_FLOP_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter next state: add one on each transition and stop at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((key_in != led_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register. It restarts from zero on reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign change_cnt = cnt_q;
`else
    assign change_cnt = '0;
`endif

endmodule

// File: tb/tb_key_flip_flop.sv
// tb_key_flip_flop: self-checking bench for key_flip_flop.
// It runs two instances on a shared stimulus: the default CNT_W=8 and CNT_W=2,
// which shows counter saturation.
// The reference keeps the history of LED values since reset. Pulses and
// transition counts are taken from that history.
module tb_key_flip_flop;

`ifdef KEY_FLIP_FLOP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int CNT_W  = 8;
    localparam int CNT_W2 = 2;

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_in    = 1'b0;

    always #10 sys_clk = ~sys_clk;

    logic              led_out,  key_rise,  key_fall;
    logic [CNT_W-1:0]  change_cnt;
    logic              led_out2, key_rise2, key_fall2;
    logic [CNT_W2-1:0] change_cnt2;

    key_flip_flop #(.CNT_W(CNT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .led_out   (led_out),
        .key_rise  (key_rise),
        .key_fall  (key_fall),
        .change_cnt(change_cnt)
    );

    key_flip_flop #(.CNT_W(CNT_W2)) dut2 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .led_out   (led_out2),
        .key_rise  (key_rise2),
        .key_fall  (key_fall2),
        .change_cnt(change_cnt2)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected LED value after every edge since the last reset.
    logic exp_q[$];

    function automatic int transitions();
        int n = 0;
        for (int i = 1; i < exp_q.size(); i++) begin
            if (exp_q[i] != exp_q[i-1]) n++;
        end
        return n;
    endfunction

    function automatic int exp_cnt(input int width);
        int cap = (1 << width) - 1;
        int t   = transitions();
        if (!STATS) return 0;
        return (t > cap) ? cap : t;
    endfunction

    function automatic logic exp_rise();
        return (exp_q.size() >= 2) && exp_q[$] && !exp_q[$-1];
    endfunction

    function automatic logic exp_fall();
        return (exp_q.size() >= 2) && !exp_q[$] && exp_q[$-1];
    endfunction

    // ---------------- driver ----------------
    // Advance one edge, update the reference, then compare all outputs of both instances.
    task automatic tick();
        @(posedge sys_clk);
        if (!sys_rst_n) begin
            exp_q.delete();
            exp_q.push_back(1'b0);
        end else begin
            exp_q.push_back(key_in);
        end
        #1;
        check("mdl_led",   {31'd0, led_out},   {31'd0, exp_q[$]});
        check("mdl_rise",  {31'd0, key_rise},  {31'd0, exp_rise()});
        check("mdl_fall",  {31'd0, key_fall},  {31'd0, exp_fall()});
        check("mdl_cnt",   32'(change_cnt),    32'(exp_cnt(CNT_W)));
        check("mdl_led2",  {31'd0, led_out2},  {31'd0, exp_q[$]});
        check("mdl_rise2", {31'd0, key_rise2}, {31'd0, exp_rise()});
        check("mdl_fall2", {31'd0, key_fall2}, {31'd0, exp_fall()});
        check("mdl_cnt2",  32'(change_cnt2),   32'(exp_cnt(CNT_W2)));
        check("excl",      {31'd0, key_rise & key_fall}, 32'd0);
    endtask

    task automatic drive(input logic rst_n, input logic key);
        sys_rst_n = rst_n;
        key_in    = key;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic k;
        int   sat_seq[6];

        // Reset held for one edge with key_in=1.
        drive(1'b0, 1'b1);
        check("rst_led",  {31'd0, led_out},  32'd0);
        check("rst_rise", {31'd0, key_rise}, 32'd0);
        check("rst_fall", {31'd0, key_fall}, 32'd0);
        check("rst_cnt",  32'(change_cnt),   32'd0);

        // Latency: the first edge after release with key_in=1.
        drive(1'b1, 1'b1);
        check("lat_led",  {31'd0, led_out},  32'd1);
        check("lat_rise", {31'd0, key_rise}, 32'd1);
        check("lat_cnt",  32'(change_cnt),   STATS ? 32'd1 : 32'd0);
        drive(1'b1, 1'b1);
        check("lat_rise_end", {31'd0, key_rise}, 32'd0);
        check("lat_led_hold", {31'd0, led_out},  32'd1);

        // Falling edge and counting.
        drive(1'b1, 1'b0);
        check("fall_pulse", {31'd0, key_fall}, 32'd1);
        check("fall_led",   {31'd0, led_out},  32'd0);
        check("fall_cnt",   32'(change_cnt),   STATS ? 32'd2 : 32'd0);
        drive(1'b1, 1'b0);
        check("fall_end",   {31'd0, key_fall}, 32'd0);

        // Random stream: key_in changes every 2 clocks.
        for (int i = 0; i < 120; i++) begin
            k = 1'($urandom_range(1, 0));
            drive(1'b1, k);
            drive(1'b1, k);
        end

        // Mid-run reset after exactly 5 transitions.
        drive(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
        check("mid_pre_cnt", 32'(change_cnt), STATS ? 32'd5 : 32'd0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        check("mid_led",  {31'd0, led_out},  32'd0);
        check("mid_rise", {31'd0, key_rise}, 32'd0);
        check("mid_cnt",  32'(change_cnt),   32'd0);
        drive(1'b1, 1'b1);
        check("mid_rel_led",  {31'd0, led_out},  32'd1);
        check("mid_rel_rise", {31'd0, key_rise}, 32'd1);
        check("mid_rel_cnt",  32'(change_cnt),   STATS ? 32'd1 : 32'd0);

        // Saturation on the CNT_W=2 instance: toggle every cycle for 6 cycles.
        drive(1'b0, 1'b0);
        sat_seq = '{1, 2, 3, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("sat_cnt2", 32'(change_cnt2), STATS ? 32'(sat_seq[i]) : 32'd0);
            check("sat_cnt",  32'(change_cnt),  STATS ? 32'(i + 1) : 32'd0);
            check("sat_alt_rise", {31'd0, key_rise}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("sat_alt_fall", {31'd0, key_fall}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
